// File: rtl/ahb3lite_csr_slave.sv
// AHB3-lite CSR responder: NRW read/write control registers driven out, NRO read-only status inputs.
// Optional CSR_WAIT_EN inserts WAIT_CYC wait states before every non-error data phase.
module ahb3lite_csr_slave #(
  parameter int unsigned NRW      = 4,
  parameter int unsigned NRO      = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              HSEL,
  input  logic [AW-1:0]     HADDR,
  input  logic [31:0]       HWDATA,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HWRITE,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [32*NRW-1:0] REG_O,
  input  logic [32*NRO-1:0] REG_I,
  output logic [NRW-1:0]    WR_STB
);
  localparam int unsigned IW = AW - 2;
`ifdef CSR_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << lo;
      3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdat,
                                              input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? wdat[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic xfer_err(input logic [2:0] size, input logic [AW-1:0] addr, input logic wr);
    logic misal;
    case (size)
      3'd0:    misal = 1'b0;
      3'd1:    misal = addr[0];
      3'd2:    misal = addr[1] | addr[0];
      default: misal = 1'b1;
    endcase
    return misal || (32'(addr[AW-1:2]) >= NRW + NRO) || (wr && (32'(addr[AW-1:2]) >= NRW));
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   rw_q [NRW];
  logic [IW-1:0] idx_p1;
  logic [3:0]    mask_p1;
  logic          write_p1;
  logic [31:0]   rdata_p1;
  logic [3:0]    wcnt_q;
  logic [NRW-1:0] stb_q;
  logic [IW-1:0] idx_a;
  logic          accept, err_a, wr_now;
  logic [31:0]   old_val, wr_val, rd_val;
  logic          unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};
  assign idx_a     = HADDR[AW-1:2];
  assign accept    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign err_a     = xfer_err(HSIZE, HADDR, HWRITE);
  assign wr_now    = (state_q == S_DATA) && write_p1;

  // A write completing this cycle is forwarded so a read accepted now sees the new value.
  always_comb begin
    old_val = '0;
    rd_val  = '0;
    for (int i = 0; i < int'(NRW); i++)
      if (idx_p1 == IW'(i)) old_val = rw_q[i];
    wr_val = merge_lanes(old_val, HWDATA, mask_p1);
    for (int i = 0; i < int'(NRW); i++)
      if (idx_a == IW'(i)) rd_val = (wr_now && idx_p1 == IW'(i)) ? wr_val : rw_q[i];
    for (int j = 0; j < int'(NRO); j++)
      if (idx_a == IW'(int'(NRW) + j)) rd_val = REG_I[32*j +: 32];
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (wcnt_q == '0) state_d = S_DATA;
      S_ERR1:  state_d = S_ERR2;
      default: begin
        if (!accept)                          state_d = S_IDLE;
        else if (err_a)                       state_d = S_ERR1;
        else if (WAIT_EN && (WAIT_CYC != 0))  state_d = S_WAIT;
        else                                  state_d = S_DATA;
      end
    endcase
  end

  always_comb begin
    HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    HRDATA    = ((state_q == S_DATA) && !write_p1) ? rdata_p1 : '0;
  end

  // address phase -> data phase (_p1)
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      idx_p1   <= '0;
      mask_p1  <= '0;
      write_p1 <= 1'b0;
      rdata_p1 <= '0;
      wcnt_q   <= '0;
      stb_q    <= '0;
      for (int i = 0; i < int'(NRW); i++) rw_q[i] <= '0;
    end else begin
      stb_q <= '0;
      if (wr_now)
        for (int i = 0; i < int'(NRW); i++)
          if (idx_p1 == IW'(i)) begin
            rw_q[i]  <= wr_val;
            stb_q[i] <= 1'b1;
          end
      if (state_q == S_WAIT) wcnt_q <= wcnt_q - 4'd1;
      if (accept) begin
        idx_p1   <= idx_a;
        mask_p1  <= lane_mask(HSIZE, HADDR[1:0]);
        write_p1 <= HWRITE;
        rdata_p1 <= HWRITE ? 32'h0 : rd_val;
        wcnt_q   <= 4'(WAIT_CYC - 1);
      end
    end
  end

  for (genvar g = 0; g < int'(NRW); g++) begin : g_rego
    assign REG_O[32*g +: 32] = rw_q[g];
  end
  assign WR_STB = stb_q;

endmodule

// File: tb/tb_ahb3lite_csr_slave.sv
// Testbench for ahb3lite_csr_slave: directed vector table, reset-in-flight sequence and random
// pipelined traffic checked against a byte-level register model.
`timescale 1ns/1ps
module tb_ahb3lite_csr_slave;
`ifdef CSR_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic         CLK, RESETn, HSEL, HWRITE, HREADYOUT, HRESP;
  logic [7:0]   HADDR;
  logic [31:0]  HWDATA, HRDATA;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE, HBURST;
  logic [3:0]   HPROT, WR_STB;
  logic [127:0] REG_O, REG_I;

  ahb3lite_csr_slave dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HREADY(HREADYOUT),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .REG_O(REG_O), .REG_I(REG_I),
    .WR_STB(WR_STB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          hand;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_stb;
  } tr_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mdl_rw [4];
  logic [31:0] mdl_ro [4];
  tr_t seq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tr_t idle_tr();
    tr_t t;
    t.sel = 1'b0; t.trans = 2'b00; t.wr = 1'b0; t.size = 3'd0; t.addr = 8'h00; t.wdata = 32'h0;
    t.hand = 1'b0; t.exp_err = 1'b0; t.exp_rd = 32'h0; t.exp_stb = 4'h0;
    return t;
  endfunction

  function automatic tr_t mk(input logic wr, input logic [2:0] size, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic err, input logic [31:0] rd,
                             input logic [3:0] stb);
    tr_t t;
    t = idle_tr();
    t.sel = 1'b1; t.trans = 2'b10; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    t.hand = 1'b1; t.exp_err = err; t.exp_rd = rd; t.exp_stb = stb;
    return t;
  endfunction

  function automatic tr_t rand_tr();
    tr_t t;
    int r;
    t = idle_tr();
    r = $urandom_range(0, 99);
    t.sel   = (r >= 5);
    t.trans = (r < 12) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    t.wr    = 1'($urandom);
    t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    t.addr  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
    if (t.size <= 3'd2 && $urandom_range(0, 9) < 7)
      t.addr = t.addr & ~((8'd1 << t.size) - 8'd1);
    t.wdata = $urandom;
    return t;
  endfunction

  // Reference model: byte-addressed register file, one completed beat at a time.
  task automatic model_apply(input tr_t t, output logic err, output logic [31:0] rd,
                             output logic [3:0] stb);
    int idx, nb, lo;
    idx = int'(t.addr) / 4;
    nb  = 1 << t.size;
    lo  = int'(t.addr) % 4;
    err = (t.size > 3'd2) || ((int'(t.addr) % nb) != 0) || (idx >= 8) || (t.wr && idx >= 4);
    rd  = 32'h0;
    stb = 4'h0;
    if (!err) begin
      if (t.wr) begin
        for (int b = lo; b < lo + nb; b++) mdl_rw[idx][8*b +: 8] = t.wdata[8*b +: 8];
        stb[idx] = 1'b1;
      end else if (idx < 4) rd = mdl_rw[idx];
      else                  rd = mdl_ro[idx-4];
    end
  endtask

  task automatic drive_bus(input tr_t t);
    HSEL = t.sel; HTRANS = t.trans; HWRITE = t.wr; HSIZE = t.size; HADDR = t.addr;
    HBURST = 3'($urandom_range(0, 7));
    HPROT  = 4'($urandom);
  endtask

  task automatic set_ro(input logic [31:0] a, b, c, d);
    mdl_ro[0] = a; mdl_ro[1] = b; mdl_ro[2] = c; mdl_ro[3] = d;
    REG_I = {d, c, b, a};
  endtask

  // Pipelined master: address of the next beat overlaps the data phase of the current one.
  task automatic run_seq();
    tr_t cur, bus;
    bit have_cur, bus_act, rdy, saw_err1;
    int waits, k, cyc;
    logic [3:0] stb_exp, e_stb, m_stb;
    logic e_err, m_err;
    logic [31:0] e_rd, m_rd;
    have_cur = 1'b0; bus_act = 1'b0; saw_err1 = 1'b0; waits = 0; k = 0; cyc = 0; stb_exp = 4'h0;
    cur = idle_tr(); bus = idle_tr();
    drive_bus(bus);
    while ((have_cur || bus_act || k < seq.size()) && cyc < 4000) begin
      @(negedge CLK);
      cyc++;
      chk("wr_stb", 128'(WR_STB), 128'(stb_exp));
      chk("reg_o", REG_O, {mdl_rw[3], mdl_rw[2], mdl_rw[1], mdl_rw[0]});
      stb_exp = 4'h0;
      rdy = HREADYOUT;
      if (!have_cur) begin
        chk("idle_resp", 128'({HREADYOUT, HRESP, HRDATA}), 128'({1'b1, 1'b0, 32'h0}));
      end else if (!HREADYOUT) begin
        waits++;
        if (HRESP) saw_err1 = 1'b1;
      end else begin
        model_apply(cur, m_err, m_rd, m_stb);
        e_err = cur.hand ? cur.exp_err : m_err;
        e_rd  = cur.hand ? cur.exp_rd  : m_rd;
        e_stb = cur.hand ? cur.exp_stb : m_stb;
        if (e_err) begin
          chk($sformatf("err_resp@%0h", cur.addr), 128'({waits, saw_err1, HRESP, HRDATA}),
              128'({32'd1, 1'b1, 1'b1, 32'h0}));
        end else begin
          chk($sformatf("ok_resp@%0h", cur.addr), 128'({waits, saw_err1, HRESP}),
              128'({EXP_WAIT, 1'b0, 1'b0}));
          if (!cur.wr) chk($sformatf("rdata@%0h", cur.addr), 128'(HRDATA), 128'(e_rd));
        end
        stb_exp = e_stb;
      end
      @(posedge CLK);
      #1;
      if (rdy) begin
        have_cur = bus_act;
        cur = bus;
        waits = 0;
        saw_err1 = 1'b0;
        HWDATA = bus_act ? bus.wdata : $urandom;
        if (k < seq.size()) begin
          bus = seq[k];
          k++;
        end else begin
          bus = idle_tr();
        end
        bus_act = bus.sel && bus.trans[1];
        drive_bus(bus);
      end
    end
    chk("seq_timeout", 128'(cyc < 4000), 128'(1));
    @(negedge CLK);
    chk("wr_stb_tail", 128'(WR_STB), 128'(stb_exp));
    chk("reg_o_tail", REG_O, {mdl_rw[3], mdl_rw[2], mdl_rw[1], mdl_rw[0]});
    seq.delete();
  endtask

  tr_t tbl [25];

  initial begin
    // Lane 1 is bits 15:8, lanes 2-3 are bits 31:16.
    tbl[0]  = mk(1'b1, 3'd2, 8'h04, 32'hDEADBEEF, 1'b0, 32'h0,        4'b0010);
    tbl[1]  = mk(1'b0, 3'd2, 8'h04, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000);
    tbl[2]  = mk(1'b1, 3'd0, 8'h05, 32'h1122AA44, 1'b0, 32'h0,        4'b0010);
    tbl[3]  = mk(1'b0, 3'd2, 8'h04, 32'h0,        1'b0, 32'hDEADAAEF, 4'b0000);
    tbl[4]  = mk(1'b1, 3'd1, 8'h03, 32'hFFFFFFFF, 1'b1, 32'h0,        4'b0000);
    tbl[5]  = mk(1'b0, 3'd2, 8'h04, 32'h0,        1'b0, 32'hDEADAAEF, 4'b0000);
    tbl[6]  = mk(1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 32'h12345678, 4'b0000);
    tbl[7]  = mk(1'b1, 3'd2, 8'h10, 32'hFFFFFFFF, 1'b1, 32'h0,        4'b0000);
    tbl[8]  = mk(1'b0, 3'd2, 8'h20, 32'h0,        1'b1, 32'h0,        4'b0000);
    tbl[9]  = mk(1'b1, 3'd2, 8'h00, 32'h11111111, 1'b0, 32'h0,        4'b0001);
    tbl[10] = mk(1'b1, 3'd2, 8'h04, 32'h22222222, 1'b0, 32'h0,        4'b0010);
    tbl[11] = mk(1'b0, 3'd2, 8'h00, 32'h0,        1'b0, 32'h11111111, 4'b0000);
    tbl[12] = mk(1'b0, 3'd2, 8'h04, 32'h0,        1'b0, 32'h22222222, 4'b0000);
    tbl[13] = mk(1'b1, 3'd2, 8'h08, 32'hCAFEF00D, 1'b0, 32'h0,        4'b0100);
    tbl[14] = mk(1'b0, 3'd2, 8'h08, 32'h0,        1'b0, 32'hCAFEF00D, 4'b0000);
    tbl[15] = mk(1'b1, 3'd1, 8'h0A, 32'h12345678, 1'b0, 32'h0,        4'b0100);
    tbl[16] = mk(1'b0, 3'd2, 8'h08, 32'h0,        1'b0, 32'h1234F00D, 4'b0000);
    tbl[17] = mk(1'b0, 3'd3, 8'h00, 32'h0,        1'b1, 32'h0,        4'b0000);
    tbl[18] = mk(1'b0, 3'd2, 8'h1C, 32'h0,        1'b0, 32'h87654321, 4'b0000);
    tbl[19] = mk(1'b0, 3'd1, 8'h06, 32'h0,        1'b0, 32'h22222222, 4'b0000);
    tbl[20] = mk(1'b0, 3'd2, 8'h02, 32'h0,        1'b1, 32'h0,        4'b0000);
    tbl[21] = mk(1'b1, 3'd0, 8'h0F, 32'h5A332211, 1'b0, 32'h0,        4'b1000);
    tbl[22] = mk(1'b0, 3'd0, 8'h0F, 32'h0,        1'b0, 32'h5A000000, 4'b0000);
    tbl[23] = mk(1'b1, 3'd2, 8'h14, 32'h01020304, 1'b1, 32'h0,        4'b0000);
    tbl[24] = mk(1'b0, 3'd2, 8'h3C, 32'h0,        1'b1, 32'h0,        4'b0000);

    for (int i = 0; i < 4; i++) mdl_rw[i] = 32'h0;
    set_ro(32'h12345678, 32'h0BADF00D, 32'h5555AAAA, 32'h87654321);
    RESETn = 1'b0;
    HWDATA = 32'h0;
    drive_bus(idle_tr());
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_bus", 128'({HREADYOUT, HRESP, HRDATA}), 128'({1'b1, 1'b0, 32'h0}));
    chk("rst_regs", 128'({REG_O, WR_STB}), 128'(0));
    @(negedge CLK);
    RESETn = 1'b1;

    for (int i = 0; i < 25; i++) seq.push_back(tbl[i]);
    run_seq();

    // Reset while a transfer is stalled (wait state, or first error cycle without waits).
    seq.push_back(mk(1'b1, 3'd2, 8'h0C, 32'h0F0F0F0F, 1'b0, 32'h0, 4'b1000));
    run_seq();
    @(posedge CLK);
    #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    HADDR = (EXP_WAIT != 0) ? 8'h0C : 8'h20;
    @(posedge CLK);
    #1;
    drive_bus(idle_tr());
    chk("stall_before_reset", 128'(HREADYOUT), 128'(0));
    #1;
    RESETn = 1'b0;
    #1;
    chk("rst_mid_bus", 128'({HREADYOUT, HRESP, HRDATA}), 128'({1'b1, 1'b0, 32'h0}));
    chk("rst_mid_regs", 128'({REG_O, WR_STB}), 128'(0));
    @(negedge CLK);
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) mdl_rw[i] = 32'h0;
    seq.push_back(mk(1'b0, 3'd2, 8'h0C, 32'h0, 1'b0, 32'h0,        4'b0000));
    seq.push_back(mk(1'b1, 3'd2, 8'h00, 32'hA5A5A5A5, 1'b0, 32'h0, 4'b0001));
    seq.push_back(mk(1'b0, 3'd2, 8'h00, 32'h0, 1'b0, 32'hA5A5A5A5, 4'b0000));
    run_seq();

    for (int b = 0; b < 4; b++) begin
      set_ro($urandom, $urandom, $urandom, $urandom);
      for (int n = 0; n < 80; n++) seq.push_back(rand_tr());
      run_seq();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
